// File: rtl/mlblock_seq_pkg.sv
// rtl/mlblock_seq_pkg.sv - shared types and sizing helpers for the MLBlock tile sequencer
package mlblock_seq_pkg;

    localparam int MODE_W = 2;
    localparam int KCNT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG   = 3'd1,
        WLOAD = 3'd2,
        COMP  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } seq_state_e;

    // Command fields that must survive past the accept edge; cfg lives in the shift register.
    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic              hp;
        logic [KCNT_W-1:0] k;
        logic              cascade;
    } cmd_t;

    function automatic int cnt_width(input int kw, input int cfg_len,
                                     input int wl_len, input int dr_len);
        int w;
        w = (kw > 1) ? kw : 1;
        if ($clog2(cfg_len) > w) w = $clog2(cfg_len);
        if ($clog2(wl_len) > w) w = $clog2(wl_len);
        if ($clog2(dr_len) > w) w = $clog2(dr_len);
        return w;
    endfunction

endpackage

// File: rtl/mlblock_seq_cnt.sv
// rtl/mlblock_seq_cnt.sv - loadable down-counter with zero flag that times every phase
module mlblock_seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         zero
);

    assign zero = (count == '0);

    // Parks at zero so IDLE/DONE need no explicit hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (!zero) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/mlblock_tile_seq.sv
// rtl/mlblock_tile_seq.sv - job sequencer driving the control pins of one MLBlock_2Dflex tile
module mlblock_tile_seq
    import mlblock_seq_pkg::*;
#(
    parameter int CFG_BITS         = 16,
    parameter int N_OF_COFIGS_LOG2 = MODE_W,
    parameter int W_LOAD_CYCLES    = 4,
    parameter int K_W              = KCNT_W,
    parameter int DRAIN_CYCLES     = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [CFG_BITS-1:0]         cmd_cfg,
    input  logic                        cmd_cfg_skip,
    input  logic [N_OF_COFIGS_LOG2-1:0] cmd_mode,
    input  logic                        cmd_hp,
    input  logic [K_W-1:0]              cmd_k,
    input  logic                        cmd_cascade,
    output logic [N_OF_COFIGS_LOG2-1:0] configg,
    output logic                        hp_en,
    output logic                        config_en,
    output logic                        config_in,
    output logic                        W_en,
    output logic                        I_en,
    output logic                        Res_en,
    output logic                        Res_cas_in_zero,
    output logic                        busy,
    output logic                        done
);

    localparam int CW = cnt_width(K_W, CFG_BITS, W_LOAD_CYCLES, DRAIN_CYCLES);
    localparam logic [CW-1:0] CFG_LAST   = CW'(CFG_BITS - 1);
    localparam logic [CW-1:0] WLOAD_LAST = CW'(W_LOAD_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    seq_state_e          state, state_nxt;
    cmd_t                cmd_r;
    logic [CFG_BITS-1:0] cfg_sr;
    logic                accept;
    logic                cnt_load, cnt_zero;
    logic [CW-1:0]       cnt_val, cnt, k_last;

    assign cmd_ready = (state == IDLE) & ~reset;
    assign accept    = cmd_valid & cmd_ready;
    assign k_last    = CW'(cmd_r.k) - CW'(1);

    mlblock_seq_cnt #(.W(CW)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_val),
        .count      (cnt),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cmd_r  <= '0;
            cfg_sr <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cmd_r  <= '{mode: cmd_mode, hp: cmd_hp, k: cmd_k, cascade: cmd_cascade};
                cfg_sr <= cmd_cfg;
            end else if (state == CFG) begin
                cfg_sr <= {cfg_sr[CFG_BITS-2:0], 1'b0};
            end
        end
    end

    // Every transition reloads the shared counter with the new phase length minus one.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    if (cmd_cfg_skip) begin
                        state_nxt = WLOAD;
                        cnt_val   = WLOAD_LAST;
                    end else begin
                        state_nxt = CFG;
                        cnt_val   = CFG_LAST;
                    end
                end
            end
            CFG: begin
                if (cnt_zero) begin
                    state_nxt = WLOAD;
                    cnt_load  = 1'b1;
                    cnt_val   = WLOAD_LAST;
                end
            end
            WLOAD: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    if (cmd_r.k == '0) begin
                        state_nxt = DRAIN;
                        cnt_val   = DRAIN_LAST;
                    end else begin
                        state_nxt = COMP;
                        cnt_val   = k_last;
                    end
                end
            end
            COMP: begin
                if (cnt_zero) begin
                    state_nxt = DRAIN;
                    cnt_load  = 1'b1;
                    cnt_val   = DRAIN_LAST;
                end
            end
            DRAIN: begin
                if (cnt_zero) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign configg   = cmd_r.mode;
    assign hp_en     = cmd_r.hp;
    assign config_en = (state == CFG);
    assign config_in = (state == CFG) & cfg_sr[CFG_BITS-1];
    assign W_en      = (state == WLOAD);
    assign I_en      = (state == COMP);
    assign Res_en    = (state == COMP);
    // The counter still holds k-1 only on the first compute cycle.
    assign Res_cas_in_zero = (state == COMP) & ~cmd_r.cascade & (cnt == k_last);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_mlblock_tile_seq.sv
// tb/tb_mlblock_tile_seq.sv - scoreboard bench for mlblock_tile_seq
module tb_mlblock_tile_seq;

    localparam int CFG_BITS = 16;
    localparam int MW       = 2;
    localparam int WL       = 4;
    localparam int KW       = 8;
    localparam int DR       = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [15:0]     cmd_cfg = '0;
    logic            cmd_cfg_skip = 1'b0;
    logic [MW-1:0]   cmd_mode = '0;
    logic            cmd_hp = 1'b0;
    logic [KW-1:0]   cmd_k = '0;
    logic            cmd_cascade = 1'b0;
    logic [MW-1:0]   configg;
    logic            hp_en, config_en, config_in, W_en, I_en, Res_en;
    logic            Res_cas_in_zero, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [11:0] sb[$];
    logic [11:0] exp_v, obs_v;

    always #5 clk = ~clk;

    mlblock_tile_seq #(
        .CFG_BITS(CFG_BITS), .N_OF_COFIGS_LOG2(MW), .W_LOAD_CYCLES(WL),
        .K_W(KW), .DRAIN_CYCLES(DR)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_cfg(cmd_cfg), .cmd_cfg_skip(cmd_cfg_skip), .cmd_mode(cmd_mode),
        .cmd_hp(cmd_hp), .cmd_k(cmd_k), .cmd_cascade(cmd_cascade),
        .configg(configg), .hp_en(hp_en), .config_en(config_en), .config_in(config_in),
        .W_en(W_en), .I_en(I_en), .Res_en(Res_en), .Res_cas_in_zero(Res_cas_in_zero),
        .busy(busy), .done(done)
    );

    function automatic logic [11:0] mk(input logic ce, input logic ci, input logic we,
                                       input logic ie, input logic re, input logic rz,
                                       input logic bz, input logic dn, input logic rdy,
                                       input logic [MW-1:0] md, input logic hp);
        return {ce, ci, we, ie, re, rz, bz, dn, rdy, md, hp};
    endfunction

    function automatic logic [11:0] obs();
        return {config_en, config_in, W_en, I_en, Res_en, Res_cas_in_zero,
                busy, done, cmd_ready, configg, hp_en};
    endfunction

    // Expected per-cycle outputs of one job, plus the idle cycle after done.
    task automatic push_job(input logic [15:0] cfg, input logic skip, input logic [MW-1:0] md,
                            input logic hp, input int k, input logic cas);
        int c, len;
        c   = skip ? 0 : CFG_BITS;
        len = c + WL + k + DR + 1;
        for (int n = 1; n <= len; n++) begin
            if (n <= c)
                sb.push_back(mk(1, cfg[CFG_BITS-n], 0, 0, 0, 0, 1, 0, 0, md, hp));
            else if (n <= c + WL)
                sb.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, md, hp));
            else if (n <= c + WL + k)
                sb.push_back(mk(0, 0, 0, 1, 1, (n == c + WL + 1) && !cas, 1, 0, 0, md, hp));
            else if (n <= c + WL + k + DR)
                sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, md, hp));
            else
                sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, md, hp));
        end
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, md, hp));
    endtask

    task automatic drive_cmd(input logic [15:0] cfg, input logic skip, input logic [MW-1:0] md,
                             input logic hp, input int k, input logic cas);
        cmd_valid    = 1'b1;
        cmd_cfg      = cfg;
        cmd_cfg_skip = skip;
        cmd_mode     = md;
        cmd_hp       = hp;
        cmd_k        = KW'(k);
        cmd_cascade  = cas;
        push_job(cfg, skip, md, hp, k, cas);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; sb.size() != 0; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = obs();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL reset cycle %0d: got %b expected %b", i, obs_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        int done_at;
        done_at = -1;
        drive_cmd(16'hA5C3, 0, 0, 0, 5, 0);
        for (int i = 1; sb.size() != 0; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (done === 1'b1 && done_at < 0) done_at = i;
            exp_v = sb.pop_front();
            obs_v = obs();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL basic cycle %0d: got %b expected %b", i, obs_v, exp_v);
            else n_pass++;
        end
        n_checks++;
        if (done_at !== 29) $display("FAIL basic_done_cycle: got %0d expected 29", done_at);
        else n_pass++;
    endtask

    task automatic test_skip_k0();
        int ien_cnt;
        ien_cnt = 0;
        drive_cmd(16'hFFFF, 1, 1, 0, 0, 0);
        for (int i = 1; sb.size() != 0; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (I_en === 1'b1) ien_cnt++;
            exp_v = sb.pop_front();
            obs_v = obs();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL skip_k0 cycle %0d: got %b expected %b", i, obs_v, exp_v);
            else n_pass++;
        end
        n_checks++;
        if (ien_cnt !== 0) $display("FAIL skip_k0_ien: got %0d expected 0", ien_cnt);
        else n_pass++;
    endtask

    task automatic test_cascade_mode();
        drive_cmd(16'h3C5A, 0, 2, 1, 3, 1);
        for (int i = 1; sb.size() != 0; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            exp_v = sb.pop_front();
            obs_v = obs();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL cascade_mode cycle %0d: got %b expected %b", i, obs_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int len1;
        len1 = WL + 2 + DR + 1;
        drive_cmd(16'h0F0F, 1, 3, 0, 2, 0);
        for (int i = 0; sb.size() != 0; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = obs();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL b2b_first cycle %0d: got %b expected %b", i + 1, obs_v, exp_v);
            else n_pass++;
            if (i < len1 - 1) begin
                cmd_cfg      = 16'($urandom);
                cmd_cfg_skip = 1'($urandom);
                cmd_mode     = MW'($urandom);
                cmd_hp       = 1'($urandom);
                cmd_k        = KW'($urandom);
                cmd_cascade  = 1'($urandom);
            end else if (i == len1 - 1) begin
                cmd_cfg      = 16'h8001;
                cmd_cfg_skip = 1'b0;
                cmd_mode     = 2'd1;
                cmd_hp       = 1'b1;
                cmd_k        = 8'd1;
                cmd_cascade  = 1'b0;
            end
        end
        push_job(16'h8001, 0, 1, 1, 1, 0);
        for (int i = 0; sb.size() != 0; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            exp_v = sb.pop_front();
            obs_v = obs();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL b2b_second cycle %0d: got %b expected %b", i + 1, obs_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_job();
        drive_cmd(16'h1234, 1, 3, 1, 10, 0);
        for (int i = 1; i <= WL + 3; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            exp_v = sb.pop_front();
            obs_v = obs();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL midreset_pre cycle %0d: got %b expected %b", i, obs_v, exp_v);
            else n_pass++;
        end
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; sb.size() != 0; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = obs();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL midreset_post cycle %0d: got %b expected %b", i, obs_v, exp_v);
            else n_pass++;
        end
        drive_cmd(16'hC001, 0, 2, 0, 2, 1);
        for (int i = 1; sb.size() != 0; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            exp_v = sb.pop_front();
            obs_v = obs();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL midreset_rerun cycle %0d: got %b expected %b", i, obs_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_k255();
        int res_cnt;
        int dones;
        res_cnt = 0;
        dones   = 0;
        drive_cmd(16'h0000, 1, 0, 1, 255, 0);
        for (int i = 1; sb.size() != 0; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (Res_en === 1'b1) res_cnt++;
            if (done === 1'b1) dones++;
            exp_v = sb.pop_front();
            obs_v = obs();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL k255 cycle %0d: got %b expected %b", i, obs_v, exp_v);
            else n_pass++;
        end
        n_checks++;
        if (res_cnt !== 255) $display("FAIL k255_res_en_count: got %0d expected 255", res_cnt);
        else n_pass++;
        n_checks++;
        if (dones !== 1) $display("FAIL k255_done_count: got %0d expected 1", dones);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skip_k0();
        test_cascade_mode();
        test_back_to_back();
        test_reset_mid_job();
        test_k255();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
